// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba multiply / product-accumulate path:
// FSM state encoding and the default accumulator sizing rule.
package karatsuba_pkg;

  // Accumulator guard bits above the 2*N product width
  localparam int ACC_GUARD = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } acc_state_t;

  // Default accumulator width for an N-bit multiplier
  function automatic int acc_w_default(input int n);
    return 2 * n + ACC_GUARD;
  endfunction

endpackage

// File: rtl/acc_adder.sv
// ACC_W-bit unsigned adder with carry-out; the carry feeds the sticky
// overflow flag of the product accumulator.
module acc_adder #(
  parameter int W = 72
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W:0] w_full;

  // Widen by one bit so the carry-out falls out of the add
  always_comb begin
    w_full  = {1'b0, i_a} + {1'b0, i_b};
    o_sum   = w_full[W-1:0];
    o_carry = w_full[W];
  end

endmodule

// File: rtl/product_accumulator.sv
// Sums a run of unsigned products from the upstream Karatsuba multiplier
// (karatsuba_overlapfree drives in_prod) into a wide accumulator and
// presents the total with a sticky overflow flag via a valid/ready pair.
module product_accumulator
  import karatsuba_pkg::*;
#(
  parameter int N     = 32,
  parameter int ACC_W = acc_w_default(N),
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  input  logic [2*N-1:0]     in_prod,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
  output logic               busy
);

  acc_state_t         r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_out_sum;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_ovf;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_accept;

  assign w_prod_ext = ACC_W'(in_prod);
  assign w_accept   = in_valid & r_in_ready;

  acc_adder #(.W(ACC_W)) u_add (
    .i_a     (r_acc),
    .i_b     (w_prod_ext),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Job FSM: start -> accumulate len products -> hold result until taken.
  // out_sum lives in its own register so it only changes on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_out_sum   <= '0;
      r_remaining <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= len;
            r_busy      <= 1'b1;
            if (len == '0) begin
              r_state     <= S_DONE;
              r_out_sum   <= '0;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= S_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc       <= w_sum;
            r_ovf       <= r_ovf | w_carry;
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == LEN_W'(1)) begin
              r_state     <= S_DONE;
              r_out_sum   <= w_sum;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_ovf;
  assign busy      = r_busy;

endmodule
